// File: rtl/gameover_overlay_ctrl.sv
// gameover_overlay_ctrl
// Sequencing and coordinate stage for the game-over banner.
// - A gameOver pulse slides the scaled 32x32 banner down from above the screen.
// - The banner then blinks for a fixed number of toggles.
// - It is then held, visible, until restart.
// Every pixel clock the block produces registered offsetX, offsetY and
// InsideRectangle for the bitmap colour lookup that follows it.
module gameover_overlay_ctrl #(
    parameter int OBJECT_WIDTH_X  = 32,
    parameter int OBJECT_HEIGHT_Y = 32,
    parameter int SCALE_SHIFT     = 3,
    parameter int TOP_LEFT_X      = 192,
    parameter int START_Y         = -256,
    parameter int TARGET_Y        = 112,
    parameter int SLIDE_STEP      = 4,
    parameter int BLINK_FRAMES    = 15,
    parameter int BLINK_TOGGLES   = 6
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        gameOver,
    input  logic        restart,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic        overlayActive,
    output logic        done
);

    // Scaled banner geometry.
    // Y values are 12-bit signed so that the off-screen start position can be
    // represented.
    localparam logic signed [11:0] BOX_W      = 12'(OBJECT_WIDTH_X << SCALE_SHIFT);
    localparam logic signed [11:0] BOX_H      = 12'(OBJECT_HEIGHT_Y << SCALE_SHIFT);
    localparam logic signed [11:0] Y_START    = 12'(START_Y);
    localparam logic signed [11:0] Y_TARGET   = 12'(TARGET_Y);
    localparam logic signed [11:0] Y_STEP     = 12'(SLIDE_STEP);
    localparam logic        [10:0] X_LO       = 11'(TOP_LEFT_X);
    localparam logic        [10:0] X_HI       = 11'(TOP_LEFT_X + int'(BOX_W));
    localparam logic        [7:0]  FRAME_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic        [7:0]  TOGGLE_LAST = 8'(BLINK_TOGGLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SLIDE_IN = 2'd1,
        ST_BLINK    = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    state_t             state_reg,  state_next;
    logic signed [11:0] top_y_reg,  top_y_next;
    logic               visible_reg, visible_next;
    logic [7:0]         frame_cnt_reg,  frame_cnt_next;
    logic [7:0]         toggle_cnt_reg, toggle_cnt_next;

    logic signed [11:0] slide_sum;

    logic [10:0]        offset_x_reg, offset_x_next;
    logic [10:0]        offset_y_reg, offset_y_next;
    logic               inside_reg,   inside_next;
    logic               active_reg;
    logic               done_reg;

    logic signed [11:0] pixel_y_s;
    logic               in_x;
    logic               in_y;
    logic [10:0]        diff_x;
    logic [10:0]        diff_y;

    // Sequencer state: state, banner top row, visibility and blink counters.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg      <= ST_IDLE;
            top_y_reg      <= Y_START;
            visible_reg    <= 1'b0;
            frame_cnt_reg  <= '0;
            toggle_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            top_y_reg      <= top_y_next;
            visible_reg    <= visible_next;
            frame_cnt_reg  <= frame_cnt_next;
            toggle_cnt_reg <= toggle_cnt_next;
        end
    end

    // Next-state logic.
    // restart overrides everything, including a simultaneous gameOver.
    // Position and visibility otherwise change only on frame boundaries, so a
    // frame is never drawn half-moved.
    always_comb begin
        state_next      = state_reg;
        top_y_next      = top_y_reg;
        visible_next    = visible_reg;
        frame_cnt_next  = frame_cnt_reg;
        toggle_cnt_next = toggle_cnt_reg;
        slide_sum       = top_y_reg + Y_STEP;

        if (restart) begin
            state_next      = ST_IDLE;
            top_y_next      = Y_START;
            visible_next    = 1'b0;
            frame_cnt_next  = '0;
            toggle_cnt_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (gameOver) begin
                        state_next   = ST_SLIDE_IN;
                        top_y_next   = Y_START;
                        visible_next = 1'b1;
                    end
                end
                ST_SLIDE_IN: begin
                    if (startOfFrame) begin
                        if (slide_sum >= Y_TARGET) begin
                            // Landed: clamp to the target and start blinking in the same cycle.
                            top_y_next      = Y_TARGET;
                            state_next      = ST_BLINK;
                            frame_cnt_next  = '0;
                            toggle_cnt_next = '0;
                        end else begin
                            top_y_next = slide_sum;
                        end
                    end
                end
                ST_BLINK: begin
                    if (startOfFrame) begin
                        if (frame_cnt_reg == FRAME_LAST) begin
                            frame_cnt_next  = '0;
                            toggle_cnt_next = toggle_cnt_reg + 8'd1;
                            visible_next    = ~visible_reg;
                            if (toggle_cnt_reg == TOGGLE_LAST) begin
                                // Final toggle: the held banner is always shown.
                                state_next   = ST_HOLD;
                                visible_next = 1'b1;
                            end
                        end else begin
                            frame_cnt_next = frame_cnt_reg + 8'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    // Static banner until restart.
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Hit test against the current banner box.
    // Rows above the screen top can never match because pixelY is never
    // negative, so a negative topY needs no special handling.
    always_comb begin
        pixel_y_s = signed'({1'b0, pixelY});
        in_x      = (pixelX >= X_LO) && (pixelX < X_HI);
        in_y      = (pixel_y_s >= top_y_reg) && (pixel_y_s < (top_y_reg + BOX_H));
        diff_x    = pixelX - X_LO;
        // The difference is non-negative and below BOX_H whenever it is
        // used, so 11 bits are sufficient.
        diff_y    = 11'(pixel_y_s - top_y_reg);

        inside_next   = visible_reg && (state_reg != ST_IDLE) && in_x && in_y;
        offset_x_next = '0;
        offset_y_next = '0;
        if (inside_next) begin
            offset_x_next = diff_x >> SCALE_SHIFT;
            offset_y_next = diff_y >> SCALE_SHIFT;
        end
    end

    // Registered outputs.
    // Coordinates appear one clock after the pixel is presented.
    // Status flags follow the state register by one clock.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            offset_x_reg <= '0;
            offset_y_reg <= '0;
            inside_reg   <= 1'b0;
            active_reg   <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            offset_x_reg <= offset_x_next;
            offset_y_reg <= offset_y_next;
            inside_reg   <= inside_next;
            active_reg   <= (state_reg != ST_IDLE);
            done_reg     <= (state_reg == ST_HOLD);
        end
    end

    assign offsetX         = offset_x_reg;
    assign offsetY         = offset_y_reg;
    assign InsideRectangle = inside_reg;
    assign overlayActive   = active_reg;
    assign done            = done_reg;

endmodule

// File: tb/tb_gameover_overlay_ctrl.sv
// Testbench for gameover_overlay_ctrl.
// Random pixel stimulus is compared against a frame-counting reference model.
// Short 8-cycle frames keep the run brief.
module tb_gameover_overlay_ctrl;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        gameOver;
    logic        restart;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        InsideRectangle;
    logic        overlayActive;
    logic        done;

    always #5 clk = ~clk;

    gameover_overlay_ctrl dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .gameOver        (gameOver),
        .restart         (restart),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .InsideRectangle (InsideRectangle),
        .overlayActive   (overlayActive),
        .done            (done)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model.
    // m_mode values: 0 idle, 1 sliding, 2 blinking, 3 holding.
    // m_bf counts frames since blinking started.
    int m_mode;
    int m_top;
    int m_vis;
    int m_bf;
    int cyc = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_top  = -256;
        m_vis  = 0;
        m_bf   = 0;
    endtask

    task automatic model_update(input bit sof, input bit go, input bit rst);
        if (rst) begin
            model_reset();
        end else begin
            case (m_mode)
                0: if (go) begin
                    m_mode = 1;
                    m_top  = -256;
                    m_vis  = 1;
                end
                1: if (sof) begin
                    m_top = (m_top + 4 > 112) ? 112 : m_top + 4;
                    if (m_top == 112) begin
                        m_mode = 2;
                        m_bf   = 0;
                    end
                end
                2: if (sof) begin
                    m_bf++;
                    if (m_bf / 15 >= 6) begin
                        m_mode = 3;
                        m_vis  = 1;
                    end else begin
                        m_vis = ((m_bf / 15) % 2 == 0) ? 1 : 0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // One clock: drive at negedge, predict, clock, update model, check at +1.
    task automatic step(input int px, input int py, input bit go, input bit rst);
        bit sof;
        int e_in, e_ox, e_oy, e_act, e_done;
        sof = (cyc % 8 == 0);
        cyc++;
        startOfFrame = sof;
        gameOver     = go;
        restart      = rst;
        pixelX       = 11'(px);
        pixelY       = 11'(py);
        e_in   = (m_vis != 0 && m_mode != 0 && px >= 192 && px < 192 + 256
                  && py >= m_top && py < m_top + 256) ? 1 : 0;
        e_ox   = (e_in != 0) ? (px - 192) / 8 : 0;
        e_oy   = (e_in != 0) ? (py - m_top) / 8 : 0;
        e_act  = (m_mode != 0) ? 1 : 0;
        e_done = (m_mode == 3) ? 1 : 0;
        @(posedge clk);
        model_update(sof, go, rst);
        #1;
        check_val("inside", int'(InsideRectangle), e_in);
        check_val("offsetX", int'(offsetX), e_ox);
        check_val("offsetY", int'(offsetY), e_oy);
        check_val("overlayActive", int'(overlayActive), e_act);
        check_val("done", int'(done), e_done);
        @(negedge clk);
    endtask

    task automatic step_rnd(input bit go, input bit rst);
        int px, py;
        px = int'($urandom_range(150, 500));
        py = int'($urandom_range(0, 479));
        step(px, py, go, rst);
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        gameOver     = 1'b0;
        restart      = 1'b0;
        #1;
        check_val("rst_async_inside", int'(InsideRectangle), 0);
        check_val("rst_async_active", int'(overlayActive), 0);
        check_val("rst_async_done", int'(done), 0);
        check_val("rst_async_offx", int'(offsetX), 0);
        check_val("rst_async_offy", int'(offsetY), 0);
        repeat (cycles) @(negedge clk);
        model_reset();
        resetN = 1'b1;
    endtask

    task automatic timeout_fail(input string tag);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got timeout expected event", tag);
    endtask

    initial begin
        int g;
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        gameOver     = 1'b0;
        restart      = 1'b0;
        pixelX       = '0;
        pixelY       = '0;
        model_reset();
        apply_reset(3);

        // Reset in the middle of the slide, then start again from the top.
        step_rnd(1'b1, 1'b0);
        repeat (30 * 8) step_rnd(1'b0, 1'b0);
        apply_reset(2);
        repeat (3) step_rnd(1'b0, 1'b0);
        step_rnd(1'b1, 1'b0);

        // Slide until the banner is partly on screen (topY = -16).
        g = 0;
        while (m_top != -16 && g < 2000) begin
            step_rnd(1'b0, 1'b0);
            g++;
        end
        if (m_top != -16) timeout_fail("wait_top_m16");
        step(192, 0, 1'b0, 1'b0);
        check_val("clip_inside", int'(InsideRectangle), 1);
        check_val("clip_offy", int'(offsetY), 2);
        step(192, 240, 1'b0, 1'b0);
        check_val("clip_row240", int'(InsideRectangle), 0);
        // A gameOver during the slide must be ignored.
        step_rnd(1'b1, 1'b0);

        // Finish the slide and land at topY = 112.
        g = 0;
        while (m_mode == 1 && g < 4000) begin
            step_rnd(1'b0, 1'b0);
            g++;
        end
        if (m_mode != 2) timeout_fail("wait_blink");
        step(200, 120, 1'b0, 1'b0);
        check_val("p200_120_inside", int'(InsideRectangle), 1);
        check_val("p200_120_offx", int'(offsetX), 1);
        check_val("p200_120_offy", int'(offsetY), 1);
        step(191, 112, 1'b0, 1'b0);
        check_val("bound_left", int'(InsideRectangle), 0);
        step(447, 367, 1'b0, 1'b0);
        check_val("bound_corner", int'(InsideRectangle), 1);
        check_val("bound_corner_offx", int'(offsetX), 31);
        check_val("bound_corner_offy", int'(offsetY), 31);
        step(448, 200, 1'b0, 1'b0);
        check_val("bound_right", int'(InsideRectangle), 0);

        // Blink through to HOLD.
        g = 0;
        while (m_mode == 2 && g < 4000) begin
            step_rnd(1'b0, 1'b0);
            g++;
        end
        if (m_mode != 3) timeout_fail("wait_hold");
        step(300, 200, 1'b0, 1'b0);
        check_val("hold_done", int'(done), 1);
        check_val("hold_inside", int'(InsideRectangle), 1);
        repeat (20) step_rnd(1'b0, 1'b0);

        // restart and gameOver together: restart wins.
        step_rnd(1'b1, 1'b1);
        step_rnd(1'b0, 1'b0);
        check_val("restart_active", int'(overlayActive), 0);
        check_val("restart_done", int'(done), 0);

        // Random phase with sporadic gameOver and restart pulses.
        for (int i = 0; i < 15000; i++) begin
            step_rnd(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 1999) == 0) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
